// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the VDC's single-port VRAM among render fetch, the CPU port and DMA,
// one access per enabled slot.
//
// Ports
//   clock_i, reset_ni        system clock, asynchronous active-low reset
//   clock_en_i               dot-clock enable; slot decisions happen only when high
//   render_*                 render read port (absolute priority, fixed one-slot latency)
//   cpu_*                    CPU read/write port; requests are 1-clock pulses
//   busy_n_o                 low while a CPU access is pending or in flight
//   dma_*                    DMA port; level request, round-robin with the CPU
//   vram_*                   registered VRAM macro interface; read data valid one slot later
//
// A grant made at slot N drives vram_* for slot N and retires at slot N+1. The next grant is
// decided in that same slot, so accesses pipeline at one per slot.

module vram_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              clock_en_i,
   input  logic              render_req_i,
   input  logic [ADDR_W-1:0] render_addr_i,
   output logic              render_ack_o,
   output logic [DATA_W-1:0] render_data_o,
   input  logic              cpu_rd_req_i,
   input  logic              cpu_wr_req_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_done_o,
   output logic              cpu_overrun_o,
   output logic              busy_n_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_ack_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic [ADDR_W-1:0] vram_addr_o,
   output logic              vram_we_o,
   output logic [DATA_W-1:0] vram_wdata_o,
   input  logic [DATA_W-1:0] vram_rdata_i
);

   // State names the access currently in flight on the VRAM bus.
   typedef enum logic [1:0] {StIdle, StGrantR, StGrantC, StGrantD} state_e;

   state_e              state_q, state_d;
   logic                rr_dma_q, rr_dma_d;      // 1: DMA wins the next CPU/DMA tie
   logic                cpu_pend_q, cpu_pend_d;  // set from request until cpu_done
   logic                cpu_we_q, cpu_we_d;
   logic [ADDR_W-1:0]   cpu_addr_q, cpu_addr_d;
   logic [DATA_W-1:0]   cpu_wdata_q, cpu_wdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                cpu_done_q, cpu_done_d;
   logic                cpu_ovr_q, cpu_ovr_d;
   logic                dma_we_q, dma_we_d;      // direction of the DMA access in flight
   logic                dma_ack_q, dma_ack_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                render_ack_q, render_ack_d;
   logic [DATA_W-1:0]   render_data_q, render_data_d;
   logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
   logic                vram_we_q, vram_we_d;
   logic [DATA_W-1:0]   vram_wdata_q, vram_wdata_d;

   logic                cpu_elig, dma_elig;

   // A requester whose access is still in flight is not regranted until it has seen its
   // done/ack, so every retirement is visible before the next decision for it.
   assign cpu_elig = cpu_pend_q && (state_q != StGrantC);
   assign dma_elig = dma_req_i && (state_q != StGrantD);

   always_comb begin
      state_d       = state_q;
      rr_dma_d      = rr_dma_q;
      cpu_pend_d    = cpu_pend_q;
      cpu_we_d      = cpu_we_q;
      cpu_addr_d    = cpu_addr_q;
      cpu_wdata_d   = cpu_wdata_q;
      cpu_rdata_d   = cpu_rdata_q;
      cpu_done_d    = 1'b0;
      cpu_ovr_d     = 1'b0;
      dma_we_d      = dma_we_q;
      dma_ack_d     = 1'b0;
      dma_rdata_d   = dma_rdata_q;
      render_ack_d  = 1'b0;
      render_data_d = render_data_q;
      vram_addr_d   = vram_addr_q;
      vram_we_d     = 1'b0;
      vram_wdata_d  = vram_wdata_q;

      // CPU request capture runs every clock, independent of the slot enable.
      if (cpu_wr_req_i || cpu_rd_req_i) begin
         if (cpu_pend_q) begin
            cpu_ovr_d = 1'b1;
         end else begin
            cpu_pend_d  = 1'b1;
            cpu_we_d    = cpu_wr_req_i;
            cpu_addr_d  = cpu_addr_i;
            cpu_wdata_d = cpu_wdata_i;
            // Simultaneous read and write: the write is kept, the read is reported dropped.
            cpu_ovr_d   = cpu_wr_req_i && cpu_rd_req_i;
         end
      end

      if (clock_en_i) begin
         // Retire the access granted in the previous slot.
         unique case (state_q)
            StGrantR: begin
               render_ack_d  = 1'b1;
               render_data_d = vram_rdata_i;
            end
            StGrantC: begin
               cpu_done_d = 1'b1;
               cpu_pend_d = 1'b0;
               if (!cpu_we_q) cpu_rdata_d = vram_rdata_i;
            end
            StGrantD: begin
               dma_ack_d = 1'b1;
               if (!dma_we_q) dma_rdata_d = vram_rdata_i;
            end
            StIdle: ;
         endcase

         // Decide this slot's grant.
         if (render_req_i) begin
            state_d     = StGrantR;
            vram_addr_d = render_addr_i;
         end else if (cpu_elig && (!dma_elig || !rr_dma_q)) begin
            state_d      = StGrantC;
            vram_addr_d  = cpu_addr_q;
            vram_we_d    = cpu_we_q;
            vram_wdata_d = cpu_wdata_q;
            rr_dma_d     = 1'b1;
         end else if (dma_elig) begin
            state_d      = StGrantD;
            vram_addr_d  = dma_addr_i;
            vram_we_d    = dma_we_i;
            vram_wdata_d = dma_wdata_i;
            dma_we_d     = dma_we_i;
            rr_dma_d     = 1'b0;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= StIdle;
         rr_dma_q      <= 1'b0;
         cpu_pend_q    <= 1'b0;
         cpu_we_q      <= 1'b0;
         cpu_addr_q    <= '0;
         cpu_wdata_q   <= '0;
         cpu_rdata_q   <= '0;
         cpu_done_q    <= 1'b0;
         cpu_ovr_q     <= 1'b0;
         dma_we_q      <= 1'b0;
         dma_ack_q     <= 1'b0;
         dma_rdata_q   <= '0;
         render_ack_q  <= 1'b0;
         render_data_q <= '0;
         vram_addr_q   <= '0;
         vram_we_q     <= 1'b0;
         vram_wdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         rr_dma_q      <= rr_dma_d;
         cpu_pend_q    <= cpu_pend_d;
         cpu_we_q      <= cpu_we_d;
         cpu_addr_q    <= cpu_addr_d;
         cpu_wdata_q   <= cpu_wdata_d;
         cpu_rdata_q   <= cpu_rdata_d;
         cpu_done_q    <= cpu_done_d;
         cpu_ovr_q     <= cpu_ovr_d;
         dma_we_q      <= dma_we_d;
         dma_ack_q     <= dma_ack_d;
         dma_rdata_q   <= dma_rdata_d;
         render_ack_q  <= render_ack_d;
         render_data_q <= render_data_d;
         vram_addr_q   <= vram_addr_d;
         vram_we_q     <= vram_we_d;
         vram_wdata_q  <= vram_wdata_d;
      end
   end

   assign render_ack_o  = render_ack_q;
   assign render_data_o = render_data_q;
   assign cpu_rdata_o   = cpu_rdata_q;
   assign cpu_done_o    = cpu_done_q;
   assign cpu_overrun_o = cpu_ovr_q;
   assign busy_n_o      = ~cpu_pend_q;
   assign dma_ack_o     = dma_ack_q;
   assign dma_rdata_o   = dma_rdata_q;
   assign vram_addr_o   = vram_addr_q;
   assign vram_we_o     = vram_we_q;
   assign vram_wdata_o  = vram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized CPU/render mix,
// checked against a VRAM shadow (ref_mem) and the arbitration rules.

module tb_vram_arbiter;

   logic        clock, reset_n, clock_en;
   logic        render_req, render_ack;
   logic [15:0] render_addr, render_data;
   logic        cpu_rd_req, cpu_wr_req, cpu_done, cpu_overrun, busy_n;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_ack;
   logic [15:0] dma_addr, dma_wdata, dma_rdata;
   logic [15:0] vram_addr, vram_wdata, vram_rdata;
   logic        vram_we;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] ref_mem [0:65535];
   logic [15:0] vmem    [0:65535];
   bit          vinit = 1'b0;

   bit          rnd_render = 1'b0;
   logic        rq_p [2];
   logic [15:0] ra_p [2];

   vram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clock_i(clock), .reset_ni(reset_n), .clock_en_i(clock_en),
      .render_req_i(render_req), .render_addr_i(render_addr),
      .render_ack_o(render_ack), .render_data_o(render_data),
      .cpu_rd_req_i(cpu_rd_req), .cpu_wr_req_i(cpu_wr_req), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done),
      .cpu_overrun_o(cpu_overrun), .busy_n_o(busy_n),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
      .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
      .vram_addr_o(vram_addr), .vram_we_o(vram_we), .vram_wdata_o(vram_wdata),
      .vram_rdata_i(vram_rdata)
   );

   function automatic logic [15:0] seed_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hA55A;
   endfunction

   // VRAM macro: combinational read, write on any clock with the strobe high.
   always @(posedge clock) begin
      if (!vinit) begin
         for (int i = 0; i < 65536; i++) vmem[i] <= seed_word(16'(i));
         vinit <= 1'b1;
      end else if (vram_we) begin
         vmem[vram_addr] <= vram_wdata;
      end
   end
   assign vram_rdata = vmem[vram_addr];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample at negedge+1. In random-render mode, check the render pipe
   // (request driven two steps ago retires now) and drive a new random request.
   task automatic step();
      @(negedge clock);
      #1;
      if (rnd_render) begin
         chk("rnd_render_ack", {31'd0, render_ack}, {31'd0, rq_p[1]});
         if (rq_p[1]) chk("rnd_render_data", {16'd0, render_data}, {16'd0, ref_mem[ra_p[1]]});
         rq_p[1] = rq_p[0];
         ra_p[1] = ra_p[0];
         rq_p[0] = ($urandom_range(0, 1) == 1);
         ra_p[0] = 16'h4000 | 16'($urandom_range(0, 16383));
         render_req  = rq_p[0];
         render_addr = ra_p[0];
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         step();
         seen = cpu_done;
      end
      chk({tag, "_done"}, {31'd0, seen}, 32'd1);
      chk({tag, "_busy_n"}, {31'd0, busy_n}, 32'd1);
   endtask

   // Returns which retirement strobe fired first: 1 = CPU, 2 = DMA, 3 = both, 0 = none.
   task automatic wait_retire(input int exp, input string tag);
      int got = 0;
      for (int i = 0; i < 12 && got == 0; i++) begin
         step();
         got = (cpu_done ? 1 : 0) + (dma_ack ? 2 : 0);
      end
      chk(tag, got, exp);
   endtask

   task automatic cpu_op(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input string tag);
      cpu_wr_req = we;
      cpu_rd_req = !we;
      cpu_addr   = a;
      cpu_wdata  = d;
      step();
      cpu_wr_req = 1'b0;
      cpu_rd_req = 1'b0;
      wait_done(tag);
      if (we) ref_mem[a] = d;
      else chk({tag, "_rdata"}, {16'd0, cpu_rdata}, {16'd0, ref_mem[a]});
   endtask

   initial begin
      logic [15:0] a, b, b2, d1, d2, d3, pa;
      logic [15:0] ra [4];
      bit          have, seen, en;

      for (int i = 0; i < 65536; i++) ref_mem[i] = seed_word(16'(i));
      reset_n = 1'b0; clock_en = 1'b1;
      render_req = 1'b0; render_addr = '0;
      cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      rq_p[0] = 1'b0; rq_p[1] = 1'b0; ra_p[0] = '0; ra_p[1] = '0;

      // Reset values
      repeat (3) step();
      chk("rst_busy_n", {31'd0, busy_n}, 32'd1);
      chk("rst_vram_we", {31'd0, vram_we}, 32'd0);
      chk("rst_vram_addr", {16'd0, vram_addr}, 32'd0);
      chk("rst_vram_wdata", {16'd0, vram_wdata}, 32'd0);
      chk("rst_render_ack", {31'd0, render_ack}, 32'd0);
      chk("rst_render_data", {16'd0, render_data}, 32'd0);
      chk("rst_cpu_done", {31'd0, cpu_done}, 32'd0);
      chk("rst_cpu_overrun", {31'd0, cpu_overrun}, 32'd0);
      chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
      chk("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
      chk("rst_dma_rdata", {16'd0, dma_rdata}, 32'd0);
      reset_n = 1'b1;
      step();

      // CPU write 0x1234 <= 0xBEEF on an idle bus
      cpu_wr_req = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'hBEEF;
      step();
      cpu_wr_req = 1'b0;
      chk("t1_busy_low", {31'd0, busy_n}, 32'd0);
      chk("t1_we_early", {31'd0, vram_we}, 32'd0);
      step();
      chk("t1_we", {31'd0, vram_we}, 32'd1);
      chk("t1_addr", {16'd0, vram_addr}, 32'h1234);
      chk("t1_wdata", {16'd0, vram_wdata}, 32'hBEEF);
      chk("t1_done_early", {31'd0, cpu_done}, 32'd0);
      step();
      chk("t1_we_off", {31'd0, vram_we}, 32'd0);
      chk("t1_done", {31'd0, cpu_done}, 32'd1);
      chk("t1_busy_n", {31'd0, busy_n}, 32'd1);
      ref_mem[16'h1234] = 16'hBEEF;
      step();
      chk("t1_done_pulse", {31'd0, cpu_done}, 32'd0);
      cpu_op(1'b0, 16'h1234, 16'h0, "t1_rb");

      // Render held 4 slots with a CPU read of 0x0010 pending: CPU gets slot 5
      for (int k = 0; k < 4; k++) ra[k] = 16'h4000 | 16'($urandom_range(0, 16383));
      render_req = 1'b1; render_addr = ra[0];
      cpu_rd_req = 1'b1; cpu_addr = 16'h0010;
      for (int k = 1; k <= 6; k++) begin
         step();
         cpu_rd_req = 1'b0;
         if (k < 4) render_addr = ra[k];
         else render_req = 1'b0;
         if (k >= 2 && k <= 5) begin
            chk("t3_render_ack", {31'd0, render_ack}, 32'd1);
            chk("t3_render_data", {16'd0, render_data}, {16'd0, ref_mem[ra[k-2]]});
            chk("t3_cpu_waits", {31'd0, cpu_done}, 32'd0);
         end
         if (k == 5) chk("t3_cpu_grant_addr", {16'd0, vram_addr}, 32'h0010);
         if (k == 6) begin
            chk("t3_cpu_done", {31'd0, cpu_done}, 32'd1);
            chk("t3_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, ref_mem[16'h0010]});
            chk("t3_busy_n", {31'd0, busy_n}, 32'd1);
            chk("t3_render_idle", {31'd0, render_ack}, 32'd0);
         end
      end

      // CPU and DMA contend; last grant was CPU so DMA leads, then they alternate
      a  = 16'($urandom_range(0, 4095));
      b  = 16'h1000 | 16'($urandom_range(0, 4095));
      b2 = 16'h2000 | 16'($urandom_range(0, 4095));
      d1 = 16'($urandom);
      d3 = 16'($urandom);
      cpu_wr_req = 1'b1; cpu_addr = a; cpu_wdata = d1;
      step();
      cpu_wr_req = 1'b0;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = b;
      wait_retire(2, "t4_first_is_dma");
      chk("t4_dma_rdata0", {16'd0, dma_rdata}, {16'd0, ref_mem[b]});
      wait_retire(1, "t4_then_cpu");
      ref_mem[a] = d1;
      wait_retire(2, "t4_then_dma");
      chk("t4_dma_rdata1", {16'd0, dma_rdata}, {16'd0, ref_mem[b]});
      dma_req = 1'b0;
      // Last grant was DMA, so the CPU leads this time
      cpu_rd_req = 1'b1; cpu_addr = a;
      step();
      cpu_rd_req = 1'b0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = b2; dma_wdata = d3;
      wait_retire(1, "t4_cpu_leads");
      chk("t4_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, ref_mem[a]});
      wait_retire(2, "t4_dma_write");
      dma_req = 1'b0;
      ref_mem[b2] = d3;
      cpu_op(1'b0, b2, 16'h0, "t4_dma_rb");

      // Second write while busy is dropped with overrun; first completes unchanged
      a  = 16'($urandom_range(0, 4095));
      d1 = 16'($urandom);
      d2 = ~d1;
      cpu_wr_req = 1'b1; cpu_addr = a; cpu_wdata = d1;
      step();
      chk("t5_busy_low", {31'd0, busy_n}, 32'd0);
      chk("t5_no_ovr_yet", {31'd0, cpu_overrun}, 32'd0);
      cpu_wdata = d2;
      step();
      cpu_wr_req = 1'b0;
      chk("t5_overrun", {31'd0, cpu_overrun}, 32'd1);
      chk("t5_we", {31'd0, vram_we}, 32'd1);
      chk("t5_wdata_first", {16'd0, vram_wdata}, {16'd0, d1});
      step();
      chk("t5_ovr_pulse", {31'd0, cpu_overrun}, 32'd0);
      chk("t5_done", {31'd0, cpu_done}, 32'd1);
      ref_mem[a] = d1;
      cpu_op(1'b0, a, 16'h0, "t5_rb");
      // Read and write in the same clock: write wins, overrun flagged
      b  = 16'($urandom_range(0, 4095));
      d3 = 16'($urandom);
      cpu_wr_req = 1'b1; cpu_rd_req = 1'b1; cpu_addr = b; cpu_wdata = d3;
      step();
      cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
      chk("t5_both_ovr", {31'd0, cpu_overrun}, 32'd1);
      chk("t5_both_busy", {31'd0, busy_n}, 32'd0);
      wait_done("t5_both");
      ref_mem[b] = d3;
      cpu_op(1'b0, b, 16'h0, "t5_both_rb");

      // Address 0xFFFF is an ordinary location
      d1 = 16'($urandom);
      cpu_op(1'b1, 16'hFFFF, d1, "t_ffff_wr");
      cpu_op(1'b0, 16'hFFFF, 16'h0, "t_ffff_rd");

      // clock_en 1-in-4 with render_req held: ack exactly one enabled slot later
      have = 1'b0;
      pa   = '0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         en = (cyc % 4 == 0);
         clock_en    = en;
         render_req  = 1'b1;
         a           = 16'h4000 | 16'($urandom_range(0, 16383));
         render_addr = a;
         step();
         chk("t7_render_ack", {31'd0, render_ack}, {31'd0, en && have});
         if (en && have) chk("t7_render_data", {16'd0, render_data}, {16'd0, ref_mem[pa]});
         if (en) begin
            pa   = a;
            have = 1'b1;
         end
      end
      render_req = 1'b0; clock_en = 1'b1;
      step();
      chk("t7_last_ack", {31'd0, render_ack}, 32'd1);
      chk("t7_last_data", {16'd0, render_data}, {16'd0, ref_mem[pa]});
      step();

      // Reset during an in-flight CPU write: strobe drops at once, access lost
      a  = 16'h3000 | 16'($urandom_range(0, 4095));
      d1 = ~ref_mem[a];
      cpu_wr_req = 1'b1; cpu_addr = a; cpu_wdata = d1;
      step();
      cpu_wr_req = 1'b0;
      step();
      chk("t6_we_before", {31'd0, vram_we}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t6_we_reset", {31'd0, vram_we}, 32'd0);
      chk("t6_busy_reset", {31'd0, busy_n}, 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         step();
         if (cpu_done) seen = 1'b1;
      end
      chk("t6_no_done", {31'd0, seen}, 32'd0);
      cpu_op(1'b0, a, 16'h0, "t6_unwritten");

      // Randomized CPU traffic under random render load
      rnd_render = 1'b1;
      for (int it = 0; it < 30; it++) begin
         a  = (it % 8 == 7) ? 16'hFFFF : 16'($urandom_range(0, 16383));
         d1 = 16'($urandom);
         cpu_op(($urandom_range(0, 1) == 1), a, d1, "rnd_cpu");
      end
      rnd_render = 1'b0;
      render_req = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
